fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue MIPS core. Maintains the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a 2-entry queue. It presents each instruction to decode together with its 16-bit immediate field and extension-type code, which drive the immediate extender directly. It also handles branch/jump redirects, including discarding stale in-flight responses.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch stage and the decode-side immediate extender.
// Holds opcode constants, extension-type codes and the default reset PC.
package cpu_pkg;

    localparam logic [5:0]  OP_ANDI          = 6'h0C;
    localparam logic [5:0]  OP_ORI           = 6'h0D;
    localparam logic [5:0]  OP_XORI          = 6'h0E;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b11
    } ext_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Only the logical immediates zero-extend; everything else sign-extends.
    function automatic ext_type_e ext_type_of(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
            return EXT_ZERO;
        end
        return EXT_SIGN;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head entry is presented combinationally.
// Push while full is accepted only if a pop happens in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, in-order memory requests, a small
// instruction queue toward decode, and redirect handling with stale-response discard.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [15:0] id_imm,
    output logic [1:0]  id_ext_type
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             accept, resp, pop_ok, keep_resp, issue_ok;
    logic [SUM_W-1:0] load;

    logic [31:0]      pcq_head;
    logic             pcq_full, pcq_empty;
    logic [CNT_W-1:0] pcq_count;

    fetch_entry_t     iq_push_data, iq_head;
    logic             iq_full, iq_empty;
    logic [CNT_W-1:0] iq_count;

    logic             unused_flags;

    always_comb begin
        pop_ok    = !iq_empty && id_ready && !redirect_valid;
        // Outstanding plus buffered work is capped so a response always finds room.
        load      = SUM_W'(inflight_q) + SUM_W'(iq_count) - SUM_W'(pop_ok);
        issue_ok  = (load < SUM_W'(DEPTH));
        imem_req_valid = rst_n && issue_ok && !redirect_valid;
        accept    = imem_req_valid && imem_req_ready;
        resp      = imem_resp_valid;
        keep_resp = resp && (discard_q == '0) && !redirect_valid;

        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp);

        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = inflight_d;
        end else if (resp && discard_q != '0) begin
            discard_d = discard_q - CNT_W'(1);
        end

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end

        iq_push_data.pc    = pcq_head;
        iq_push_data.instr = imem_resp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc_q),
        .pop       (resp),
        .head_data (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data (iq_push_data),
        .pop       (pop_ok),
        .head_data (iq_head),
        .full      (iq_full),
        .empty     (iq_empty),
        .count     (iq_count)
    );

    assign imem_addr   = pc_q;
    assign id_valid    = !iq_empty;
    assign id_instr    = iq_head.instr;
    assign id_pc       = iq_head.pc;
    assign id_imm      = iq_head.instr[15:0];
    assign id_ext_type = ext_type_of(iq_head.instr);

    assign unused_flags = ^{pcq_full, pcq_empty, pcq_count, iq_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory of programmable latency.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [15:0] id_imm;
    logic [1:0]  id_ext_type;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_imm          (id_imm),
        .id_ext_type     (id_ext_type)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h3421_FFFF;
            32'h14:  return 32'h2021_FFFF;
            32'h18:  return 32'h3000_1234;
            32'h1C:  return 32'h3800_8000;
            default: return 32'h2000_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    function automatic logic [1:0] exp_ext(input logic [31:0] a);
        case (a)
            32'h10, 32'h18, 32'h1C: return 2'b11;
            default:                return 2'b00;
        endcase
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t pend[$];
    int    tick = 0;
    int    lat  = 1;

    initial begin : mem_model
        logic        acc;
        logic [31:0] acc_addr;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = rst_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            tick++;
            if (!rst_n) begin
                pend.delete();
            end else if (acc) begin
                pend.push_back('{acc_addr, tick + lat - 1});
            end
            if (rst_n && pend.size() > 0 && pend[0].due <= tick) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = instr_at(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin : main
        logic [31:0] ea;
        logic [31:0] ei;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        cyc();
        cyc();
        smp();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_imm", id_imm, 0);
        chk("rst_ext", id_ext_type, 0);

        // Streaming with 1-cycle memory and decode always ready
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            smp();
            chk($sformatf("s1_rv%0d", k), imem_req_valid, 1);
            chk($sformatf("s1_addr%0d", k), imem_addr, 32'(4 * k));
            if (k < 2) begin
                chk($sformatf("s1_idv%0d", k), id_valid, 0);
            end else begin
                ea = 32'(4 * (k - 2));
                ei = instr_at(ea);
                chk($sformatf("s1_idv%0d", k), id_valid, 1);
                chk($sformatf("s1_idpc%0d", k), id_pc, ea);
                chk($sformatf("s1_instr%0d", k), id_instr, ei);
                chk($sformatf("s1_imm%0d", k), id_imm, {16'h0, ei[15:0]});
                chk($sformatf("s1_ext%0d", k), id_ext_type, exp_ext(ea));
            end
            if (k == 6) begin
                chk("ori_imm", id_imm, 32'h0000_FFFF);
                chk("ori_ext", id_ext_type, 2'b11);
            end
            if (k == 7) begin
                chk("addi_ext", id_ext_type, 2'b00);
            end
            cyc();
        end

        // Decode stalls: two entries buffered, no further issue
        id_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            smp();
            chk($sformatf("s2_rv%0d", j), imem_req_valid, 0);
            chk($sformatf("s2_idv%0d", j), id_valid, 1);
            chk($sformatf("s2_idpc%0d", j), id_pc, 32'h20);
            chk($sformatf("s2_addr%0d", j), imem_addr, 32'h28);
            cyc();
        end
        id_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            smp();
            chk($sformatf("s2r_idpc%0d", j), id_pc, 32'(32'h20 + 4 * j));
            chk($sformatf("s2r_addr%0d", j), imem_addr, 32'(32'h28 + 4 * j));
            chk($sformatf("s2r_rv%0d", j), imem_req_valid, 1);
            cyc();
        end

        // Memory back-pressure: address held until accepted
        imem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            smp();
            chk($sformatf("s3_rv%0d", j), imem_req_valid, 1);
            chk($sformatf("s3_addr%0d", j), imem_addr, 32'h38);
            if (j == 2) chk("s3_idv_drained", id_valid, 0);
            cyc();
        end
        imem_req_ready = 1'b1;
        lat = 3;
        smp();
        chk("s3_addr_acc", imem_addr, 32'h38);
        cyc();
        smp();
        chk("s3_addr_next", imem_addr, 32'h3C);
        chk("s3_rv_next", imem_req_valid, 1);
        cyc();

        // Redirect with two requests in flight on 3-cycle memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        smp();
        chk("s4_rv_redir", imem_req_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk("s4_idv_after", id_valid, 0);
        chk("s4_addr_after", imem_addr, 32'h100);
        chk("s4_rv_full", imem_req_valid, 0);
        cyc();
        smp();
        chk("s4_rv_issue", imem_req_valid, 1);
        chk("s4_addr_issue", imem_addr, 32'h100);
        chk("s4_idv_drop1", id_valid, 0);
        cyc();
        for (int j = 0; j < 3; j++) begin
            smp();
            chk($sformatf("s4_idv_wait%0d", j), id_valid, 0);
            cyc();
        end
        smp();
        chk("s4_idv", id_valid, 1);
        chk("s4_idpc", id_pc, 32'h100);
        chk("s4_instr", id_instr, instr_at(32'h100));
        cyc();
        smp();
        chk("s4_idpc2", id_pc, 32'h104);
        cyc();

        // Redirect coinciding with a response on 1-cycle memory
        id_ready = 1'b0;
        for (int j = 0; j < 10; j++) cyc();
        smp();
        chk("s5_rv_full", imem_req_valid, 0);
        chk("s5_idv_full", id_valid, 1);
        lat = 1;
        cyc();
        id_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        smp();
        chk("s5_rv_redir", imem_req_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk("s5_idv_after", id_valid, 0);
        chk("s5_rv_after", imem_req_valid, 1);
        chk("s5_addr_after", imem_addr, 32'h200);
        cyc();
        smp();
        chk("s5_idv_resp", id_valid, 0);
        cyc();
        smp();
        chk("s5_idv", id_valid, 1);
        chk("s5_idpc", id_pc, 32'h200);
        chk("s5_instr", id_instr, instr_at(32'h200));
        chk("s5_addr", imem_addr, 32'h208);
        cyc();
        cyc();

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rv", imem_req_valid, 0);
        chk("s6_addr", imem_addr, 32'h0);
        chk("s6_idv", id_valid, 0);
        chk("s6_instr", id_instr, 0);
        chk("s6_idpc", id_pc, 0);
        chk("s6_imm", id_imm, 0);
        chk("s6_ext", id_ext_type, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        smp();
        chk("s6r_rv", imem_req_valid, 1);
        chk("s6r_addr0", imem_addr, 32'h0);
        cyc();
        smp();
        chk("s6r_addr1", imem_addr, 32'h4);
        chk("s6r_idv0", id_valid, 0);
        cyc();
        smp();
        chk("s6r_addr2", imem_addr, 32'h8);
        chk("s6r_idv1", id_valid, 1);
        chk("s6r_idpc", id_pc, 32'h0);
        chk("s6r_instr", id_instr, instr_at(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
